// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-atomic arbiter that lets N_REQ byte sources share one UART transmit FIFO.
// Optional owner watchdog is built only when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int bits    = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0]      last,
  input  logic [N_REQ*bits-1:0] data_in,
  input  logic                  full,
  output logic [N_REQ-1:0]      ack,
  output logic                  write_en,
  output logic [bits-1:0]       data_out,
  output logic [N_REQ-1:0]      grant,
  output logic                  busy,
  output logic                  timeout
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t           state_r;
  logic [PW-1:0]    owner_r;
  logic [PW-1:0]    ptr_r;
  logic [N_REQ-1:0] grant_r;
  logic             busy_r;

  logic [PW-1:0]    winner_s;
  logic             found_s;
  logic             accept_s;
  logic             wdog_fire_s;

  function automatic logic [N_REQ-1:0] onehot(input logic [PW-1:0] idx);
    logic [N_REQ-1:0] v;
    v = '0;
    for (int i = 0; i < N_REQ; i++) begin
      v[i] = (idx == PW'(i));
    end
    return v;
  endfunction

  // round-robin search starting one past the last released owner
  always_comb begin
    int idx;
    winner_s = ptr_r;
    found_s  = 1'b0;
    idx      = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr_r) + k) % N_REQ;
      if (!found_s && req[idx]) begin
        winner_s = PW'(idx);
        found_s  = 1'b1;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // same-cycle accept strobe, owner ack and data mux
  always_comb begin
    ack = '0;
    if (state_r == LOCK) begin
      accept_s = req[owner_r] & ~full;
    end else begin
      accept_s = 1'b0;
    end
    for (int i = 0; i < N_REQ; i++) begin
      ack[i] = accept_s & (owner_r == PW'(i));
    end
    data_out = data_in[int'(owner_r)*bits +: bits];
  end

  assign write_en = accept_s;
  assign grant    = grant_r;
  assign busy     = busy_r;

  // ownership state machine; a release of either kind makes the owner lowest priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      owner_r <= '0;
      ptr_r   <= PW'(N_REQ - 1);
      grant_r <= '0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (found_s) begin
            state_r <= LOCK;
            owner_r <= winner_s;
            grant_r <= onehot(winner_s);
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        LOCK: begin
          if ((accept_s && last[owner_r]) || wdog_fire_s) begin
            state_r <= IDLE;
            ptr_r   <= owner_r;
            grant_r <= '0;
            busy_r  <= 1'b0;
          end else begin
            state_r <= LOCK;
          end
        end
        default: begin
          state_r <= IDLE;
          grant_r <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] idle_cnt_r;
  logic          timeout_r;

  // fires on the TIMEOUT-th silent owner cycle, so the pulse appears TIMEOUT cycles after the drop
  assign wdog_fire_s = (state_r == LOCK) && !req[owner_r] && !full &&
                       (idle_cnt_r == CW'(TIMEOUT - 1));

  // owner-silence counter and forced-release pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt_r <= '0;
      timeout_r  <= 1'b0;
    end else begin
      timeout_r <= wdog_fire_s;
      if (state_r != LOCK || accept_s) begin
        idle_cnt_r <= '0;
      end else if (!req[owner_r] && !full) begin
        idle_cnt_r <= idle_cnt_r + CW'(1);
      end else begin
        idle_cnt_r <= idle_cnt_r;
      end
    end
  end

  assign timeout = timeout_r;
`else
  assign wdog_fire_s = 1'b0;
  assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int B  = 8;
  localparam int TO = 10;

  logic             clk;
  logic             rst;
  logic [N-1:0]     req;
  logic [N-1:0]     last;
  logic [N*B-1:0]   data_in;
  logic             full;
  logic [N-1:0]     ack;
  logic             write_en;
  logic [B-1:0]     data_out;
  logic [N-1:0]     grant;
  logic             busy;
  logic             timeout;

  int tests;
  int fails;

  uart_tx_arbiter #(.N_REQ(N), .bits(B), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .last(last), .data_in(data_in), .full(full),
    .ack(ack), .write_en(write_en), .data_out(data_out), .grant(grant), .busy(busy),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // requester sources: bytes left in current packet and the packet bytes
  int           src_left [N];
  int           src_idx  [N];
  logic [B-1:0] src_data [N][8];
  logic [N-1:0] src_hold;
  logic [N-1:0] acked;

  // reference model: owner index (-1 = none), priority pointer, silent-owner count
  int           m_owner;
  int           m_ptr;
  int           m_idle;
  logic         m_to;
  logic [N-1:0] e_ack, e_grant;
  logic         e_we, e_busy, e_to;
  logic [B-1:0] e_data;

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic void model_eval();
    e_grant = '0; e_ack = '0; e_we = 1'b0; e_data = '0;
    e_busy  = (m_owner >= 0);
    e_to    = m_to;
    if (m_owner >= 0) begin
      e_grant[m_owner] = 1'b1;
      e_we             = req[m_owner] && !full;
      e_ack[m_owner]   = e_we;
      e_data           = data_in[m_owner*B +: B];
    end
  endfunction

  function automatic void model_step();
    m_to = 1'b0;
    if (m_owner < 0) begin
      for (int k = 1; k <= N; k++)
        if (m_owner < 0 && req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
      m_idle = 0;
    end else if (e_we) begin
      m_idle = 0;
      if (last[m_owner]) begin m_ptr = m_owner; m_owner = -1; end
    end else if (!req[m_owner] && !full) begin
`ifdef UART_ARB_TIMEOUT_EN
      m_idle++;
      if (m_idle == TO) begin m_to = 1'b1; m_ptr = m_owner; m_owner = -1; end
`endif
    end
  endfunction

  task automatic load_pkt(input int ch, input int n);
    src_left[ch] = n;
    src_idx[ch]  = 0;
    for (int k = 0; k < n; k++) src_data[ch][k] = B'($urandom_range(0, 255));
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req[i]            = (src_left[i] > 0) && !src_hold[i];
      last[i]           = (src_left[i] == 1);
      data_in[i*B +: B] = src_data[i][src_idx[i] % 8];
    end
  endtask

  // sample, advance model across the edge, then retire acked bytes
  task automatic pre_cycle();
    drive();
    #1;
    model_eval();
  endtask

  task automatic post_cycle();
    acked = ack;
    model_step();
    @(negedge clk);
    for (int i = 0; i < N; i++)
      if (acked[i] && src_left[i] > 0) begin src_left[i]--; src_idx[i]++; end
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; last = '0; data_in = '0; full = 1'b0; src_hold = '0; acked = '0;
    for (int i = 0; i < N; i++) begin src_left[i] = 0; src_idx[i] = 0; end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    m_owner = -1; m_ptr = N - 1; m_idle = 0; m_to = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; last = '0; data_in = '0; full = 1'b0;
    #1;
    tests++; if (grant !== 4'b0000) begin fails++; $display("FAIL rst_grant got=%b exp=0000", grant); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got=%b exp=0", busy); end
    tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL rst_timeout got=%b exp=0", timeout); end
    tests++; if (write_en !== 1'b0) begin fails++; $display("FAIL rst_we got=%b exp=0", write_en); end
    tests++; if (ack !== 4'b0000) begin fails++; $display("FAIL rst_ack got=%b exp=0000", ack); end
    do_reset();
    for (int c = 0; c < 3; c++) begin
      pre_cycle();
      tests++; if (busy !== 1'b0 || grant !== 4'b0000) begin
        fails++; $display("FAIL idle_noreq cyc=%0d busy=%b grant=%b exp 0/0000", c, busy, grant);
      end
      post_cycle();
    end
    load_pkt(1, 1);
    pre_cycle(); post_cycle();
    pre_cycle();
    tests++; if (grant !== 4'b0010) begin fails++; $display("FAIL first_arb got=%b exp=0010", grant); end
    post_cycle();
  endtask

  task automatic test_two_channels();
    logic [N-1:0] g_tab [7];
    logic         w_tab [7];
    logic [B-1:0] exp_q [$];
    do_reset();
    load_pkt(0, 2); load_pkt(2, 2);
    exp_q = '{src_data[0][0], src_data[0][1], src_data[2][0], src_data[2][1]};
    g_tab = '{4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0100, 4'b0100, 4'b0000};
    w_tab = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int c = 0; c < 7; c++) begin
      pre_cycle();
      tests++; if (grant !== g_tab[c]) begin fails++; $display("FAIL two_grant cyc=%0d got=%b exp=%b", c, grant, g_tab[c]); end
      tests++; if (write_en !== w_tab[c]) begin fails++; $display("FAIL two_we cyc=%0d got=%b exp=%b", c, write_en, w_tab[c]); end
      if (w_tab[c] && exp_q.size() > 0) begin
        tests++; if (data_out !== exp_q[0]) begin fails++; $display("FAIL two_data cyc=%0d got=%h exp=%h", c, data_out, exp_q[0]); end
        exp_q.pop_front();
      end
      post_cycle();
    end
  endtask

  task automatic test_rotation();
    int order [$];
    int acks  [N];
    int exp_order [5];
    exp_order = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < N; i++) begin load_pkt(i, 1); acks[i] = 0; end
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < N; i++) if (src_left[i] == 0) load_pkt(i, 1);
      pre_cycle();
      if (grant !== 4'b0000 && write_en === 1'b1) order.push_back(oh_idx(grant));
      if (c < 8) for (int i = 0; i < N; i++) if (ack[i]) acks[i]++;
      post_cycle();
    end
    tests++; if (order.size() != 5) begin fails++; $display("FAIL rot_count got=%0d exp=5", order.size()); end
    for (int k = 0; k < 5 && k < order.size(); k++) begin
      tests++; if (order[k] != exp_order[k]) begin fails++; $display("FAIL rot_order k=%0d got=%0d exp=%0d", k, order[k], exp_order[k]); end
    end
    for (int i = 0; i < N; i++) begin
      tests++; if (acks[i] != 1) begin fails++; $display("FAIL rot_acks ch=%0d got=%0d exp=1", i, acks[i]); end
    end
  endtask

  task automatic test_full_stall();
    int writes;
    writes = 0;
    do_reset();
    load_pkt(1, 1);
    src_data[1][0] = 8'hA5;
    for (int c = 0; c < 8; c++) begin
      full = (c >= 1 && c <= 5);
      pre_cycle();
      if (write_en === 1'b1) writes++;
      if (c >= 1 && c <= 5) begin
        tests++; if (write_en !== 1'b0 || ack !== 4'b0000) begin
          fails++; $display("FAIL stall_hold cyc=%0d we=%b ack=%b exp 0/0000", c, write_en, ack);
        end
        tests++; if (grant !== 4'b0010) begin fails++; $display("FAIL stall_grant cyc=%0d got=%b exp=0010", c, grant); end
      end
      if (c == 6) begin
        tests++; if (write_en !== 1'b1 || ack !== 4'b0010 || data_out !== 8'hA5) begin
          fails++; $display("FAIL stall_release we=%b ack=%b data=%h exp 1/0010/a5", write_en, ack, data_out);
        end
      end
      post_cycle();
    end
    full = 1'b0;
    tests++; if (writes != 1) begin fails++; $display("FAIL stall_writes got=%0d exp=1", writes); end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    load_pkt(3, 4);
    for (int c = 0; c < 3; c++) begin pre_cycle(); post_cycle(); end
    rst = 1'b1;
    drive();
    #1;
    tests++; if (grant !== 4'b0000 || busy !== 1'b0) begin fails++; $display("FAIL midrst_grant grant=%b busy=%b exp 0000/0", grant, busy); end
    tests++; if (write_en !== 1'b0 || ack !== 4'b0000) begin fails++; $display("FAIL midrst_we we=%b ack=%b exp 0/0000", write_en, ack); end
    @(negedge clk);
    rst = 1'b0;
    m_owner = -1; m_ptr = N - 1; m_idle = 0; m_to = 1'b0;
    load_pkt(3, 2);
    pre_cycle();
    tests++; if (grant !== 4'b0000) begin fails++; $display("FAIL midrst_idle got=%b exp=0000", grant); end
    post_cycle();
    pre_cycle();
    tests++; if (grant !== 4'b1000) begin fails++; $display("FAIL midrst_regrant got=%b exp=1000", grant); end
    post_cycle();
  endtask

  task automatic test_owner_drop();
    int to_cyc, g0_cyc, pulses;
    to_cyc = -1; g0_cyc = -1; pulses = 0;
    do_reset();
    load_pkt(2, 3);
    for (int c = 0; c < 40; c++) begin
      if (c == 2) begin src_hold[2] = 1'b1; load_pkt(0, 1); end
      pre_cycle();
      tests++; if (grant !== e_grant || timeout !== e_to || write_en !== e_we) begin
        fails++; $display("FAIL drop_model cyc=%0d grant=%b to=%b we=%b exp %b/%b/%b", c, grant, timeout, write_en, e_grant, e_to, e_we);
      end
      if (timeout === 1'b1) begin pulses++; if (to_cyc < 0) to_cyc = c; end
      if (grant === 4'b0001 && g0_cyc < 0) g0_cyc = c;
      post_cycle();
    end
`ifdef UART_ARB_TIMEOUT_EN
    tests++; if (pulses != 1) begin fails++; $display("FAIL drop_pulses got=%0d exp=1", pulses); end
    tests++; if (to_cyc != 2 + TO) begin fails++; $display("FAIL drop_to_cyc got=%0d exp=%0d", to_cyc, 2 + TO); end
    tests++; if (g0_cyc != to_cyc + 1) begin fails++; $display("FAIL drop_ch0 got=%0d exp=%0d", g0_cyc, to_cyc + 1); end
`else
    tests++; if (pulses != 0) begin fails++; $display("FAIL drop_pulses got=%0d exp=0", pulses); end
    tests++; if (grant !== 4'b0100 || g0_cyc != -1) begin fails++; $display("FAIL drop_hold grant=%b ch0_cyc=%0d exp 0100/-1", grant, g0_cyc); end
`endif
    src_hold = '0;
  endtask

  task automatic test_random();
    int open_ch, c_ch;
    open_ch = -1;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++)
        if (src_left[i] == 0 && ($urandom % 3) == 0) load_pkt(i, $urandom_range(1, 4));
      full = (($urandom % 4) == 0);
      pre_cycle();
      tests++; if (grant !== e_grant || busy !== e_busy) begin fails++; $display("FAIL rnd_grant cyc=%0d got=%b/%b exp=%b/%b", c, grant, busy, e_grant, e_busy); end
      tests++; if (ack !== e_ack || write_en !== e_we) begin fails++; $display("FAIL rnd_ack cyc=%0d got=%b/%b exp=%b/%b", c, ack, write_en, e_ack, e_we); end
      tests++; if (timeout !== e_to) begin fails++; $display("FAIL rnd_timeout cyc=%0d got=%b exp=%b", c, timeout, e_to); end
      if (e_we) begin
        tests++; if (data_out !== e_data) begin fails++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", c, data_out, e_data); end
      end
      if (write_en === 1'b1) begin
        c_ch = oh_idx(ack);
        tests++; if (c_ch < 0 || (open_ch >= 0 && c_ch != open_ch)) begin
          fails++; $display("FAIL rnd_atomic cyc=%0d got_ch=%0d exp_ch=%0d", c, c_ch, open_ch);
        end
        if (c_ch >= 0) open_ch = last[c_ch] ? -1 : c_ch;
      end
      post_cycle();
    end
    full = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0;
    src_hold = '0; acked = '0;
    test_reset();
    test_two_channels();
    test_rotation();
    test_full_stall();
    test_reset_mid_packet();
    test_owner_drop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
